// File: rtl/seg_rx_pkg.sv
// Shared constants and types for the seven-segment frame receiver.
// Segment patterns are listed g..a (bit6..bit0), active-high.
package seg_rx_pkg;

  localparam logic [6:0] SEG_0     = 7'b0111111;
  localparam logic [6:0] SEG_1     = 7'b0000110;
  localparam logic [6:0] SEG_2     = 7'b1011011;
  localparam logic [6:0] SEG_3     = 7'b1001111;
  localparam logic [6:0] SEG_4     = 7'b1100110;
  localparam logic [6:0] SEG_5     = 7'b1101101;
  localparam logic [6:0] SEG_6     = 7'b1111101;
  localparam logic [6:0] SEG_7     = 7'b0000111;
  localparam logic [6:0] SEG_8     = 7'b1111111;
  localparam logic [6:0] SEG_9     = 7'b1101111;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  typedef enum logic [1:0] {
    WAIT_ONES = 2'd0,
    WAIT_TENS = 2'd1,
    CHECK     = 2'd2
  } state_e;

endpackage

// File: rtl/seg7_digit_dec.sv
// Combinational seven-segment decoder: pattern to BCD digit plus valid flag.
// Blank is reported invalid here; the caller decides where blank is allowed.
module seg7_digit_dec
  import seg_rx_pkg::*;
(
  input  logic [6:0] pat_i,
  output logic [3:0] digit_o,
  output logic       valid_o
);

  always_comb begin
    digit_o = '0;
    valid_o = 1'b1;
    case (pat_i)
      SEG_0:   digit_o = 4'd0;
      SEG_1:   digit_o = 4'd1;
      SEG_2:   digit_o = 4'd2;
      SEG_3:   digit_o = 4'd3;
      SEG_4:   digit_o = 4'd4;
      SEG_5:   digit_o = 4'd5;
      SEG_6:   digit_o = 4'd6;
      SEG_7:   digit_o = 4'd7;
      SEG_8:   digit_o = 4'd8;
      SEG_9:   digit_o = 4'd9;
      default: valid_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg_frame_rx.sv
// Two-digit seven-segment frame receiver with stability filtering (0..15).
// Define SEGRX_ACTIVE_LOW_EN for active-low segment inputs.
module seg_frame_rx
  import seg_rx_pkg::*;
#(
  parameter int unsigned STABLE_CNT = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] seg,
  input  logic       seg_dig,
  input  logic       seg_vld,
  output logic [3:0] out_val,
  output logic       out_vld,
  output logic       out_err
);

  localparam logic [3:0] STABLE_W = 4'(STABLE_CNT);

  logic [6:0] seg_in;
`ifdef SEGRX_ACTIVE_LOW_EN
  assign seg_in = ~seg;
`else
  assign seg_in = seg;
`endif

  state_e     state_q, state_d;
  logic [6:0] ones_q, ones_d, tens_q, tens_d;
  logic [3:0] cnt_q, cnt_d, cand_q, cand_d, val_q, val_d;
  logic       emitted_q, emitted_d, vld_q, vld_d, err_q, err_d;

  logic [3:0] ones_dig, tens_raw, tens_dig;
  logic       ones_ok, tens_raw_ok, tens_ok, frame_ok;
  logic [6:0] sum;

  seg7_digit_dec u_dec_ones (.pat_i(ones_q), .digit_o(ones_dig), .valid_o(ones_ok));
  seg7_digit_dec u_dec_tens (.pat_i(tens_q), .digit_o(tens_raw), .valid_o(tens_raw_ok));

  // Blank is a legal leading zero on the tens digit only.
  assign tens_ok  = tens_raw_ok || (tens_q == SEG_BLANK);
  assign tens_dig = (tens_q == SEG_BLANK) ? 4'd0 : tens_raw;
  assign sum      = ({3'b000, tens_dig} * 7'd10) + {3'b000, ones_dig};
  assign frame_ok = ones_ok && tens_ok && (tens_dig <= 4'd1) && (sum <= 7'd15);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= WAIT_ONES;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      WAIT_ONES: if (seg_vld && !seg_dig) state_d = WAIT_TENS;
      WAIT_TENS: if (seg_vld && seg_dig)  state_d = CHECK;
      CHECK:     state_d = WAIT_ONES;
      default:   state_d = WAIT_ONES;
    endcase
  end

  always_comb begin
    ones_d    = ones_q;
    tens_d    = tens_q;
    cnt_d     = cnt_q;
    cand_d    = cand_q;
    val_d     = val_q;
    emitted_d = emitted_q;
    vld_d     = 1'b0;
    err_d     = 1'b0;
    case (state_q)
      WAIT_ONES: begin
        if (seg_vld) begin
          if (!seg_dig) ones_d = seg_in;
          else          err_d  = 1'b1;
        end
      end
      WAIT_TENS: begin
        if (seg_vld) begin
          if (seg_dig) tens_d = seg_in;
          else         ones_d = seg_in;
        end
      end
      CHECK: begin
        if (!frame_ok) begin
          err_d = 1'b1;
          cnt_d = '0;
        end else begin
          // A zero count means no live candidate, so any valid frame restarts it.
          if ((cnt_q != '0) && (sum[3:0] == cand_q)) begin
            if (cnt_q < STABLE_W) cnt_d = cnt_q + 4'd1;
          end else begin
            cand_d = sum[3:0];
            cnt_d  = 4'd1;
          end
          if ((cnt_d == STABLE_W) && (!emitted_q || (cand_d != val_q))) begin
            vld_d     = 1'b1;
            val_d     = cand_d;
            emitted_d = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ones_q    <= '0;
      tens_q    <= '0;
      cnt_q     <= '0;
      cand_q    <= '0;
      val_q     <= '0;
      emitted_q <= 1'b0;
      vld_q     <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      ones_q    <= ones_d;
      tens_q    <= tens_d;
      cnt_q     <= cnt_d;
      cand_q    <= cand_d;
      val_q     <= val_d;
      emitted_q <= emitted_d;
      vld_q     <= vld_d;
      err_q     <= err_d;
    end
  end

  assign out_val = val_q;
  assign out_vld = vld_q;
  assign out_err = err_q;

endmodule

// File: tb/tb_seg_frame_rx.sv
// Directed bench for seg_frame_rx; patterns are given active-high and
// inverted on the way in when SEGRX_ACTIVE_LOW_EN is defined.
module tb_seg_frame_rx;

`ifdef SEGRX_ACTIVE_LOW_EN
  localparam logic [6:0] INV = 7'h7f;
`else
  localparam logic [6:0] INV = 7'h00;
`endif

  localparam logic [6:0] P0 = 7'b0111111;
  localparam logic [6:0] P1 = 7'b0000110;
  localparam logic [6:0] P2 = 7'b1011011;
  localparam logic [6:0] P3 = 7'b1001111;
  localparam logic [6:0] P5 = 7'b1101101;
  localparam logic [6:0] P6 = 7'b1111101;
  localparam logic [6:0] P7 = 7'b0000111;
  localparam logic [6:0] PB = 7'b0000000;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] seg = INV;
  logic       seg_dig = 1'b0;
  logic       seg_vld = 1'b0;
  logic [3:0] out_val;
  logic       out_vld, out_err;

  int tests = 0;
  int fails = 0;

  seg_frame_rx #(.STABLE_CNT(2)) dut (
    .clk(clk), .rst_n(rst_n), .seg(seg), .seg_dig(seg_dig), .seg_vld(seg_vld),
    .out_val(out_val), .out_vld(out_vld), .out_err(out_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst_n && (out_vld || out_err)) begin
      tests++;
      if (out_vld && out_err) begin
        fails++;
        $display("FAIL exclusive: vld=%b err=%b, required not both high", out_vld, out_err);
      end
    end
  end

  task automatic send_beat(input logic [6:0] pat, input logic dig);
    @(negedge clk);
    seg     = pat ^ INV;
    seg_dig = dig;
    seg_vld = 1'b1;
    @(negedge clk);
    seg_vld = 1'b0;
  endtask

  task automatic check_out(input string name, input logic ev, input logic ee, input logic [3:0] eval);
    tests++;
    if ({out_vld, out_err, out_val} !== {ev, ee, eval}) begin
      fails++;
      $display("FAIL %s: vld/err/val got %b/%b/%0d required %b/%b/%0d",
               name, out_vld, out_err, out_val, ev, ee, eval);
    end
  endtask

  task automatic do_frame(input logic [6:0] ones, input logic [6:0] tens, input string name,
                          input logic ev, input logic ee, input logic [3:0] eval);
    logic [3:0] prev;
    send_beat(ones, 1'b0);
    send_beat(tens, 1'b1);
    prev = out_val;
    check_out({name, "_early"}, 1'b0, 1'b0, prev);
    @(negedge clk);
    check_out(name, ev, ee, eval);
  endtask

  task automatic test_reset;
    #1;
    check_out("reset_hold", 1'b0, 1'b0, 4'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_out("reset_release", 1'b0, 1'b0, 4'd0);
  endtask

  task automatic test_stable_three;
    do_frame(P3, PB, "three_f1", 1'b0, 1'b0, 4'd0);
    do_frame(P3, PB, "three_f2", 1'b1, 1'b0, 4'd3);
  endtask

  task automatic test_max_fifteen;
    do_frame(P5, P1, "fifteen_f1", 1'b0, 1'b0, 4'd3);
    do_frame(P5, P1, "fifteen_f2", 1'b1, 1'b0, 4'd15);
    for (int i = 0; i < 3; i++) do_frame(P5, P1, "fifteen_rep", 1'b0, 1'b0, 4'd15);
  endtask

  task automatic test_errors;
    do_frame(P6, P1, "err_sixteen", 1'b0, 1'b1, 4'd15);
    do_frame(P0, P2, "err_tens2", 1'b0, 1'b1, 4'd15);
    do_frame(PB, P1, "err_blank_ones", 1'b0, 1'b1, 4'd15);
    do_frame(7'b1010101, PB, "err_bad_pat", 1'b0, 1'b1, 4'd15);
  endtask

  task automatic test_protocol;
    send_beat(P3, 1'b1);
    check_out("tens_in_wait_ones", 1'b0, 1'b1, 4'd15);
    for (int i = 0; i < 2; i++) begin
      send_beat(P7, 1'b0);
      do_frame(P1, PB, "ones_replace", (i == 1), 1'b0, (i == 1) ? 4'd1 : 4'd15);
    end
  endtask

  task automatic test_ten;
    do_frame(P0, P1, "ten_f1", 1'b0, 1'b0, 4'd1);
    do_frame(P0, P1, "ten_f2", 1'b1, 1'b0, 4'd10);
  endtask

  task automatic test_reset_mid_frame;
    send_beat(P3, 1'b0);
    rst_n = 1'b0;
    #1;
    check_out("async_reset", 1'b0, 1'b0, 4'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check_out("no_pulse_release", 1'b0, 1'b0, 4'd0);
    send_beat(P1, 1'b1);
    check_out("tens_after_reset", 1'b0, 1'b1, 4'd0);
  endtask

  task automatic test_zero_first_emit;
    do_frame(P0, PB, "zero_f1", 1'b0, 1'b0, 4'd0);
    do_frame(P0, PB, "zero_f2", 1'b1, 1'b0, 4'd0);
  endtask

  task automatic test_seven;
    do_frame(P7, PB, "seven_f1", 1'b0, 1'b0, 4'd0);
    do_frame(P7, PB, "seven_f2", 1'b1, 1'b0, 4'd7);
    @(negedge clk);
    check_out("seven_hold", 1'b0, 1'b0, 4'd7);
  endtask

  initial begin
    test_reset();
    test_stable_three();
    test_max_fifteen();
    test_errors();
    test_protocol();
    test_ten();
    test_reset_mid_frame();
    test_zero_first_emit();
    test_seven();
    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
